// File: rtl/uart_rx_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | uart_rx_pkg : UART state encodings and oversampling constants         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  localparam int unsigned c_oversample = 16;
  localparam logic [3:0]  c_sample_lo  = 4'd7;
  localparam logic [3:0]  c_sample_mid = 4'd8;
  localparam logic [3:0]  c_sample_hi  = 4'd9;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | uart_baud_tick : single-cycle tick every DIV clocks, phase clearable  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module uart_baud_tick #(
  parameter int DIV = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int c_cw = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(DIV - 1);

  logic [c_cw-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == c_last)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cw'(1);
    end
  end

  // A clear restarts the phase, so no tick may leak out on that cycle.
  assign tick = (r_cnt == c_last) && !clr;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | uart_rx : 8N1 receiver, 16x oversampling, 3-sample majority vote      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200,
  parameter int DIV      = CLK_FREQ / (BAUD * 16)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  state_t     r_state, w_state_nxt;
  logic       r_rx_meta, r_rx_s;
  logic       w_tick, w_clr;
  logic [3:0] r_sample, w_sample_nxt;
  logic       r_s_lo, r_s_mid;
  logic       w_vote, w_vote_en;
  logic [2:0] r_bitcnt;
  logic [7:0] r_shreg;
  logic       w_shift, w_bit_clr, w_deliver, w_ferr;
  logic       r_deliver;
  logic [7:0] r_rx_data;
  logic       r_rx_valid, r_frame_err, r_overrun;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .tick (w_tick)
  );

  assign w_sample_nxt = r_sample + 4'd1;
  assign w_vote_en    = w_tick && (w_sample_nxt == c_sample_hi);
  assign w_vote       = maj3(r_s_lo, r_s_mid, r_rx_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_shift     = 1'b0;
    w_bit_clr   = 1'b0;
    w_deliver   = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = ST_START;
          w_clr       = 1'b1;
        end
      end
      ST_START: begin
        if (w_vote_en) begin
          if (!w_vote) begin
            w_state_nxt = ST_DATA;
            w_bit_clr   = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (w_vote_en) begin
          w_shift = 1'b1;
          if (r_bitcnt == 3'd7) w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_vote_en) begin
          if (w_vote) begin
            w_deliver   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        // A held-low line must go high before a new start can be seen.
        if (r_rx_s) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_sample  <= 4'd0;
      r_s_lo    <= 1'b1;
      r_s_mid   <= 1'b1;
      r_bitcnt  <= 3'd0;
      r_shreg   <= 8'h00;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      if (w_clr) begin
        r_sample <= 4'd0;
      end else if (w_tick) begin
        r_sample <= w_sample_nxt;
      end
      if (w_tick && (w_sample_nxt == c_sample_lo))  r_s_lo  <= r_rx_s;
      if (w_tick && (w_sample_nxt == c_sample_mid)) r_s_mid <= r_rx_s;
      if (w_bit_clr) begin
        r_bitcnt <= 3'd0;
      end else if (w_shift) begin
        r_bitcnt <= r_bitcnt + 3'd1;
      end
      if (w_shift) r_shreg <= {w_vote, r_shreg[7:1]};
    end
  end

  // Delivery lands one clock after the stop vote; the shift register is
  // quiet in that cycle, so it can be copied directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_deliver   <= 1'b0;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_deliver   <= w_deliver;
      r_frame_err <= w_ferr;
      r_overrun   <= 1'b0;
      if (r_deliver) begin
        if (r_rx_valid && !rx_ready) begin
          r_overrun <= 1'b1;
        end else begin
          r_rx_data  <= r_shreg;
          r_rx_valid <= 1'b1;
        end
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire
